mem_arbiter: RTL



---
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester main-memory arbiter for the icache and dcache management units.
// A requester keeps the port for as long as its cs stays high, so bursts are
// never interleaved. Contention alternates between the two units, and a sticky
// flag reports a memory that stops acknowledging.
module mem_arbiter #(
    parameter int TIMEOUT  = 64,
    parameter int TO_WIDTH = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_cs_i,
    input  logic        d_cs_i,
    input  logic        i_we_i,
    input  logic        d_we_i,
    input  logic [31:0] i_addr_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] i_data_i,
    input  logic [31:0] d_data_i,
    output logic [31:0] i_data_o,
    output logic [31:0] d_data_o,
    output logic        i_ack_o,
    output logic        d_ack_o,
    output logic        mem_cs_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_ack_i,
    output logic [1:0]  grant_o,
    output logic        err_timeout_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    localparam logic [TO_WIDTH-1:0] TO_MAX = TO_WIDTH'(TIMEOUT);

    state_t              state;
    state_t              state_next;
    logic                last_dcache;
    logic [TO_WIDTH-1:0] to_cnt;
    logic                granted_cs;

    // Read data goes to both caches; only the ack tells a unit the word is its own.
    assign i_data_o = mem_data_i;
    assign d_data_o = mem_data_i;

    // State register; last-served tracks whichever grant is being entered or held.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last_dcache <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next == GNT_I) begin
                last_dcache <= 1'b0;
            end else if (state_next == GNT_D) begin
                last_dcache <= 1'b1;
            end
        end
    end

    // Next-state: hold while the owner's cs is high, hand off directly when it drops.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_cs_i && d_cs_i) begin
                    state_next = last_dcache ? GNT_I : GNT_D;
                end else if (i_cs_i) begin
                    state_next = GNT_I;
                end else if (d_cs_i) begin
                    state_next = GNT_D;
                end
            end
            GNT_I: begin
                if (!i_cs_i) begin
                    state_next = d_cs_i ? GNT_D : IDLE;
                end
            end
            GNT_D: begin
                if (!d_cs_i) begin
                    state_next = i_cs_i ? GNT_I : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Port mux and ack steering follow the registered owner; idle drives zeros.
    always_comb begin
        mem_cs_o   = 1'b0;
        mem_we_o   = 1'b0;
        mem_addr_o = 32'd0;
        mem_data_o = 32'd0;
        i_ack_o    = 1'b0;
        d_ack_o    = 1'b0;
        grant_o    = 2'b00;
        granted_cs = 1'b0;
        case (state)
            GNT_I: begin
                mem_cs_o   = i_cs_i;
                mem_we_o   = i_we_i;
                mem_addr_o = i_addr_i;
                mem_data_o = i_data_i;
                i_ack_o    = mem_ack_i;
                grant_o    = 2'b01;
                granted_cs = i_cs_i;
            end
            GNT_D: begin
                mem_cs_o   = d_cs_i;
                mem_we_o   = d_we_i;
                mem_addr_o = d_addr_i;
                mem_data_o = d_data_i;
                d_ack_o    = mem_ack_i;
                grant_o    = 2'b10;
                granted_cs = d_cs_i;
            end
            default: ;
        endcase
    end

    // Count unacknowledged owned cycles; reaching the limit latches the error until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt        <= '0;
            err_timeout_o <= 1'b0;
        end else if (state == IDLE || mem_ack_i || state_next != state) begin
            to_cnt <= '0;
        end else if (granted_cs && to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + TO_WIDTH'(1);
            if (to_cnt + TO_WIDTH'(1) == TO_MAX) begin
                err_timeout_o <= 1'b1;
            end
        end
    end

endmodule
